uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the UART driver library.

---
 rtl/uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Parametrised UART transmitter with an input FIFO and valid/ready handshake.
//   The frame format is set at elaboration time: 5..8 data bits sent LSB first,
//   optional odd/even parity, and 1 or 2 stop bits. Queued words go out
//   back-to-back. There is no idle gap between consecutive frames.
//
// Parameters
//   BAUD_DIV   clk_50m cycles per bit (>= 2)
//   DATA_BITS  data bits per frame (5..8)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//   FIFO_AW    FIFO address width, depth = 2**FIFO_AW (>= 1)
//
// Ports
//   clk_50m     in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   tx_data     in   word to queue
//   tx_valid    in   tx_data valid
//   tx_ready    out  FIFO can accept a word (= !full)
//   uart_tx     out  serial line, idle high, registered
//   tx_busy     out  a frame is on the line
//   tx_done     out  one-cycle pulse after each frame's last stop bit
//   fifo_count  out  words currently queued (0..2**FIFO_AW)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [FIFO_AW:0]     fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int BCW   = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [BCW-1:0]   BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BCW-1:0]   BAUD_ZERO = BCW'(0);
    localparam logic [BCW-1:0]   BAUD_ONE  = BCW'(1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a data word: odd makes the total number of ones odd,
    // even makes it even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        if (PARITY == 1) begin
            parity_bit = ~(^word);
        end else begin
            parity_bit = ^word;
        end
    endfunction

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic [DATA_BITS-1:0] head_s;

    // Full/empty come from the extra pointer MSB. Equal low bits with a
    // differing MSB means the write pointer has lapped the read pointer.
    always_comb begin
        fifo_full_s  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        fifo_empty_s = (wr_ptr_q == rd_ptr_q);
        head_s       = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    end

    // Push uses the registered full flag only. A same-cycle pop therefore
    // never makes room for a push in that cycle.
    always_comb begin
        push_s   = tx_valid & ~fifo_full_s;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q[FIFO_AW-1:0]] <= tx_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [BCW-1:0]       baud_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 uart_tx_q;
    logic                 tx_busy_q;
    logic                 tx_done_q;
    logic                 baud_end_s;
    logic                 frame_end_s;

    // A pop happens when the FSM is idle, or at the edge that ends the last
    // stop bit. The second case chains the next frame with no gap.
    always_comb begin
        baud_end_s  = (baud_cnt_q == BAUD_LAST);
        frame_end_s = (state_q == ST_STOP) && baud_end_s && (bit_cnt_q == STOP_LAST);
        if (!fifo_empty_s && ((state_q == ST_IDLE) || frame_end_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Frame sequencer. The line value for each bit is registered at the
    // edge that starts that bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= BAUD_ZERO;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    baud_cnt_q <= BAUD_ZERO;
                    bit_cnt_q  <= 4'd0;
                    if (pop_s) begin
                        shift_q   <= head_s;
                        par_q     <= parity_bit(head_s);
                        uart_tx_q <= 1'b0;
                        tx_busy_q <= 1'b1;
                        state_q   <= ST_START;
                    end else begin
                        uart_tx_q <= 1'b1;
                        tx_busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= BAUD_ZERO;
                        bit_cnt_q  <= 4'd0;
                        uart_tx_q  <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        state_q    <= ST_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= BAUD_ZERO;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= 4'd0;
                            if (PARITY != 0) begin
                                uart_tx_q <= par_q;
                                state_q   <= ST_PARITY;
                            end else begin
                                uart_tx_q <= 1'b1;
                                state_q   <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            uart_tx_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                ST_PARITY: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= BAUD_ZERO;
                        bit_cnt_q  <= 4'd0;
                        uart_tx_q  <= 1'b1;
                        state_q    <= ST_STOP;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_q <= BAUD_ZERO;
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= 4'd0;
                            tx_done_q <= 1'b1;
                            if (pop_s) begin
                                shift_q   <= head_s;
                                par_q     <= parity_bit(head_s);
                                uart_tx_q <= 1'b0;
                                state_q   <= ST_START;
                            end else begin
                                uart_tx_q <= 1'b1;
                                tx_busy_q <= 1'b0;
                                state_q   <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                default: begin
                    baud_cnt_q <= BAUD_ZERO;
                    bit_cnt_q  <= 4'd0;
                    uart_tx_q  <= 1'b1;
                    tx_busy_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx    = uart_tx_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign tx_ready   = ~fifo_full_s;
    assign fifo_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Two instances: A = 8E1, BAUD_DIV 4, depth 4; B = 5O2, BAUD_DIV 3, depth 4.
//   A reference model tracks each block as a word queue plus a "cycles into
//   current frame" counter. Every clock, the expected line, busy, done, ready
//   and count are derived from that counter and the frame bit layout.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic [7:0] d0;
    logic       v0;
    logic       ready0, line0, busy0, done0;
    logic [2:0] count0;
    logic [4:0] d1;
    logic       v1;
    logic       ready1, line1, busy1, done1;
    logic [2:0] count1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_50m = ~clk_50m;

    uart_tx_fifo #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) dut_a (
        .clk_50m(clk_50m), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(ready0),
        .uart_tx(line0), .tx_busy(busy0), .tx_done(done0), .fifo_count(count0));

    uart_tx_fifo #(.BAUD_DIV(3), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2), .FIFO_AW(2)) dut_b (
        .clk_50m(clk_50m), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(ready1),
        .uart_tx(line1), .tx_busy(busy1), .tx_done(done1), .fifo_count(count1));

    // ---------------- reference model ----------------
    logic [7:0] mbuf [2][4];
    int         mcnt [2];
    int         ft   [2];   // cycles into current frame, -1 when idle
    logic [7:0] cur  [2];
    logic       mdone[2];
    int         acc_cnt [2];
    int         done_obs[2];

    function automatic int bdiv(int k);  return (k == 0) ? 4 : 3; endfunction
    function automatic int dbits(int k); return (k == 0) ? 8 : 5; endfunction
    function automatic int par(int k);   return (k == 0) ? 2 : 1; endfunction
    function automatic int stops(int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int flen(int k);
        return (1 + dbits(k) + ((par(k) != 0) ? 1 : 0) + stops(k)) * bdiv(k);
    endfunction

    function automatic logic exp_line(int k);
        int i;
        int ones;
        if (ft[k] < 0) return 1'b1;
        i = ft[k] / bdiv(k);
        if (i == 0) return 1'b0;
        if (i <= dbits(k)) return cur[k][i-1];
        if (par(k) != 0 && i == dbits(k) + 1) begin
            ones = 0;
            for (int b = 0; b < dbits(k); b++) ones += int'(cur[k][b]);
            // Parity bit value that makes the total ones odd (1) or even (2).
            if (par(k) == 1) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
            else return ((ones % 2) == 1) ? 1'b1 : 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; ft[k] = -1; cur[k] = 8'h00; mdone[k] = 1'b0;
        end
    endtask

    task automatic model_edge(int k, logic acc, logic [7:0] d);
        logic start_new;
        start_new = 1'b0;
        mdone[k]  = 1'b0;
        if (ft[k] < 0) begin
            start_new = (mcnt[k] > 0);
        end else if (ft[k] == flen(k) - 1) begin
            mdone[k]  = 1'b1;
            start_new = (mcnt[k] > 0);
            if (!start_new) ft[k] = -1;
        end else begin
            ft[k] = ft[k] + 1;
        end
        if (start_new) begin
            cur[k] = mbuf[k][0];
            for (int j = 0; j < 3; j++) mbuf[k][j] = mbuf[k][j+1];
            mcnt[k] = mcnt[k] - 1;
            ft[k]   = 0;
        end
        if (acc) begin
            mbuf[k][mcnt[k]] = d;
            mcnt[k] = mcnt[k] + 1;
            acc_cnt[k] = acc_cnt[k] + 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("A_uart_tx",    {7'd0, line0},  {7'd0, exp_line(0)});
        chk("A_tx_busy",    {7'd0, busy0},  {7'd0, ft[0] >= 0});
        chk("A_tx_done",    {7'd0, done0},  {7'd0, mdone[0]});
        chk("A_tx_ready",   {7'd0, ready0}, {7'd0, mcnt[0] < 4});
        chk("A_fifo_count", {5'd0, count0}, 8'(mcnt[0]));
        chk("B_uart_tx",    {7'd0, line1},  {7'd0, exp_line(1)});
        chk("B_tx_busy",    {7'd0, busy1},  {7'd0, ft[1] >= 0});
        chk("B_tx_done",    {7'd0, done1},  {7'd0, mdone[1]});
        chk("B_tx_ready",   {7'd0, ready1}, {7'd0, mcnt[1] < 4});
        chk("B_fifo_count", {5'd0, count1}, 8'(mcnt[1]));
    endtask

    task automatic chk_reset();
        chk("A_rst_uart_tx", {7'd0, line0},  8'd1);
        chk("A_rst_busy",    {7'd0, busy0},  8'd0);
        chk("A_rst_done",    {7'd0, done0},  8'd0);
        chk("A_rst_ready",   {7'd0, ready0}, 8'd1);
        chk("A_rst_count",   {5'd0, count0}, 8'd0);
        chk("B_rst_uart_tx", {7'd0, line1},  8'd1);
        chk("B_rst_busy",    {7'd0, busy1},  8'd0);
        chk("B_rst_done",    {7'd0, done1},  8'd0);
        chk("B_rst_ready",   {7'd0, ready1}, 8'd1);
        chk("B_rst_count",   {5'd0, count1}, 8'd0);
    endtask

    // One clock: decide acceptance from the model's pre-edge occupancy,
    // advance the model on the edge, then compare 1 time unit later.
    task automatic step();
        logic a0, a1;
        a0 = v0 && (mcnt[0] < 4);
        a1 = v1 && (mcnt[1] < 4);
        @(posedge clk_50m);
        model_edge(0, a0, d0);
        model_edge(1, a1, {3'b000, d1});
        #1;
        if (done0) done_obs[0]++;
        if (done1) done_obs[1]++;
        check_all();
    endtask

    initial begin
        int target;
        rst_n = 1'b0;
        v0 = 1'b0; d0 = 8'h00;
        v1 = 1'b0; d1 = 5'h00;
        acc_cnt[0] = 0; acc_cnt[1] = 0;
        done_obs[0] = 0; done_obs[1] = 0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk_50m);
        #1;
        chk_reset();
        @(negedge clk_50m);
        rst_n = 1'b1;
        step();

        // Single frames into idle blocks: 0x55 on A, 5'h1F on B
        d0 = 8'h55; v0 = 1'b1; d1 = 5'h1F; v1 = 1'b1;
        step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (50) step();

        // Parity: 0x07 (three ones) and 5'h03 (two ones)
        d0 = 8'h07; v0 = 1'b1; d1 = 5'h03; v1 = 1'b1;
        step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (50) step();

        // Hold tx_valid on A until 5 words accepted: fills, stalls, refills
        target = acc_cnt[0] + 5;
        done_obs[0] = 0;
        v0 = 1'b1;
        for (int i = 0; i < 300 && acc_cnt[0] < target; i++) begin
            d0 = 8'($urandom);
            step();
        end
        v0 = 1'b0;
        repeat (5 * 44 + 10) step();
        chk("A_burst_done_pulses", 8'(done_obs[0]), 8'd5);

        // Same on B with two stop bits
        target = acc_cnt[1] + 5;
        done_obs[1] = 0;
        v1 = 1'b1;
        for (int i = 0; i < 300 && acc_cnt[1] < target; i++) begin
            d1 = 5'($urandom);
            step();
        end
        v1 = 1'b0;
        repeat (5 * 27 + 10) step();
        chk("B_burst_done_pulses", 8'(done_obs[1]), 8'd5);

        // Randomised traffic with mixed load
        for (int i = 0; i < 1500; i++) begin
            v0 = ($urandom_range(0, 9) < ((i < 750) ? 2 : 7));
            v1 = ($urandom_range(0, 9) < ((i < 750) ? 7 : 2));
            d0 = 8'($urandom);
            d1 = 5'($urandom);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (4 * 44 + 10) step();

        // Reset in the middle of a data bit with words still queued
        v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d0 = 8'($urandom); d1 = 5'($urandom);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (14) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset();
        model_reset();
        @(negedge clk_50m);
        @(negedge clk_50m);
        chk_reset();
        rst_n = 1'b1;
        step();

        // Clean frame after reset
        d0 = 8'hA3; v0 = 1'b1; d1 = 5'h0A; v1 = 1'b1;
        step();
        v0 = 1'b0; v1 = 1'b0;
        repeat (50) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
